// File: rtl/proc_mem_pkg.sv
// Shared types for the store path between the control unit and data memory.
// Store sizes, store-merge FSM states and byte-lane helper functions.
package proc_mem_pkg;

  localparam int unsigned LANES = 8;

  typedef enum logic [1:0] {
    SZ_D = 2'b00,
    SZ_W = 2'b01,
    SZ_H = 2'b10,
    SZ_B = 2'b11
  } store_size_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    DROP
  } smu_state_t;

  // Offset bits that must be zero for a naturally aligned store of this size.
  function automatic logic [2:0] offset_low_mask(store_size_t size);
    logic [2:0] m;
    unique case (size)
      SZ_D:    m = 3'b111;
      SZ_W:    m = 3'b011;
      SZ_H:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [LANES-1:0] lane_mask(store_size_t size, logic [2:0] offset);
    logic [LANES-1:0] base;
    unique case (size)
      SZ_D:    base = 8'hFF;
      SZ_W:    base = 8'h0F;
      SZ_H:    base = 8'h03;
      default: base = 8'h01;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Store request and data-memory signals of the store merge unit.
// master: control unit / memory side, slave: store_merge_unit.
interface store_merge_unit_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              DMemWrite;
  logic [1:0]        tam;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              misalign;

  modport master (
    output DMemWrite, tam, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, misalign
  );

  modport slave (
    input  DMemWrite, tam, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, misalign
  );
endinterface

// File: rtl/store_merge_unit_byte_merge.sv
// Combinational byte-lane merge: places LSB-justified store data into the
// selected lanes of the old doubleword and reports natural-alignment violations.
module store_byte_merge
  import proc_mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  store_size_t       size,
  input  logic [2:0]        offset,
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  output logic [DATA_W-1:0] merged,
  output logic [LANES-1:0]  lane_en,
  output logic              misaligned
);

  logic [DATA_W-1:0] shifted;

  assign misaligned = |(offset & offset_low_mask(size));
  assign lane_en    = lane_mask(size, offset);
  assign shifted    = new_data << {offset, 3'b000};

  always_comb begin
    merged = old_data;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = shifted[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: turns sd/sw/sh/sb store commands into doubleword memory
// writes, using read-modify-write for sub-doubleword stores.
//
// state | meaning
// IDLE  | waiting for DMemWrite; request captured here
// READ  | aligned address on the bus, counting out the memory read latency
// MERGE | read data valid; merged doubleword registered into mem_wdata
// WRITE | mem_we and done pulse for one cycle
// DROP  | misaligned store discarded; done and misalign pulse for one cycle
module store_merge_unit
  import proc_mem_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int MEM_RD_LAT  = 1,
  parameter int CHECK_ALIGN = 1
) (
  input logic               clk,
  input logic               reset,
  store_merge_unit_if.slave bus
);

  localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_RD_LAT - 1);

  smu_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  store_size_t       size_q, size_nxt;
  logic [2:0]        off_q, off_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              misalign_q, misalign_nxt;

  store_size_t       live_size;
  logic [2:0]        raw_off, eff_off;
  store_size_t       mrg_size;
  logic [2:0]        mrg_off;
  logic [DATA_W-1:0] mrg_new;
  logic [DATA_W-1:0] merged;
  logic [LANES-1:0]  lane_en;
  logic              misaligned;
  logic              full_lanes;

  assign live_size = store_size_t'(bus.tam);
  assign raw_off   = bus.addr[2:0];
  // Without alignment checking the low offset bits are simply truncated away.
  assign eff_off   = (CHECK_ALIGN != 0) ? raw_off : (raw_off & ~offset_low_mask(live_size));

  // In IDLE the merger classifies the live request; afterwards it works on the captured one.
  assign mrg_size = (state == IDLE) ? live_size : size_q;
  assign mrg_off  = (state == IDLE) ? eff_off   : off_q;
  assign mrg_new  = (state == IDLE) ? bus.wdata : data_q;

  store_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .size       (mrg_size),
    .offset     (mrg_off),
    .old_data   (bus.mem_rdata),
    .new_data   (mrg_new),
    .merged     (merged),
    .lane_en    (lane_en),
    .misaligned (misaligned)
  );

  assign full_lanes = (lane_en == {LANES{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    size_nxt      = size_q;
    off_nxt       = off_q;
    data_nxt      = data_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    mem_we_nxt    = 1'b0;
    done_nxt      = 1'b0;
    misalign_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.DMemWrite) begin
          size_nxt     = live_size;
          off_nxt      = eff_off;
          data_nxt     = bus.wdata;
          mem_addr_nxt = {bus.addr[ADDR_W-1:3], 3'b000};
          if ((CHECK_ALIGN != 0) && misaligned) begin
            state_nxt    = DROP;
            done_nxt     = 1'b1;
            misalign_nxt = 1'b1;
          end else if (full_lanes) begin
            state_nxt     = WRITE;
            mem_wdata_nxt = merged;
            mem_we_nxt    = 1'b1;
            done_nxt      = 1'b1;
          end else begin
            state_nxt = READ;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      READ: begin
        if (cnt == '0) state_nxt = MERGE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      MERGE: begin
        state_nxt     = WRITE;
        mem_wdata_nxt = merged;
        mem_we_nxt    = 1'b1;
        done_nxt      = 1'b1;
      end
      WRITE:   state_nxt = IDLE;
      DROP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      size_q      <= SZ_D;
      off_q       <= '0;
      data_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      size_q      <= size_nxt;
      off_q       <= off_nxt;
      data_q      <= data_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      mem_we_q    <= mem_we_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      misalign_q  <= misalign_nxt;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.misalign  = misalign_q;

endmodule
